dev_bus_host: RTL and testbench
===============================

# dev_bus_host

Single-outstanding initiator for the simple device bus (req / addr / we / be / wdata out, rvalid / rdata in) used by the system's memory-mapped peripherals such as the GPIO block. It accepts one command at a time on a valid/ready command port, issues exactly one single-cycle device request, and waits for the responder's rvalid. If rvalid does not arrive within a bounded number of cycles, it returns an error response. It is used to drive peripherals from non-CPU masters, such as test sequencers and debug bridges.

## Interface
- AddrWidth, 32, device address width
- DataWidth, 32, device data width
- TimeoutCycles, 16, maximum WAIT cycles before error; must be ≥1
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset (one clock; asynchronous active-high reset)
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_addr_i  in  AddrWidth  target address
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_be_i  in  4  byte enables
- cmd_wdata_i  in  DataWidth  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o
- rsp_rdata_o  out  DataWidth  read data; 0 for writes and errors
- rsp_err_o  out  1  1 = timeout
- device_req_o  out  1  device request, one cycle per transaction
- device_addr_o, device_we_o, device_be_o, device_wdata_o  out  AddrWidth/1/4/DataWidth  request fields
- device_rvalid_i  in  1  responder completion (reads and writes)
- device_rdata_i  in  DataWidth  read data, valid with device_rvalid_i
- busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i & cmd_ready_o, register addr/we/be/wdata and go to REQ.
- REQ:
  - device_req_o=1 for exactly this one cycle; device_* fields come from the registered command.
  - Clear the timer to 0 and go to WAIT.
- WAIT (device_req_o=0):
  - If device_rvalid_i: capture device_rdata_i if the command is a read (else 0), set err=0, go to RESP.
  - Else increment the timer.
  - If the timer reaches TimeoutCycles with no rvalid (i.e. after TimeoutCycles WAIT cycles), set rdata=0, err=1, go to RESP.
  - rvalid on the TimeoutCycles-th WAIT cycle wins over the timeout (err=0).
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o held stable until rsp_ready_i.
  - On handshake, go to IDLE.
- Timer width is $clog2(TimeoutCycles+1) bits and never wraps.
- device_rvalid_i in IDLE, REQ or RESP (late or stray) is ignored and changes no state.
- device_* fields hold the last command's values outside REQ; consumers qualify them with device_req_o.
- cmd_ready_o=0 in REQ/WAIT/RESP, so there is never more than one transaction outstanding.

## Timing
- Reset values (asserted asynchronously, while rst_i high and after release):
  - state=IDLE, so cmd_ready_o=1 and busy_o=0.
  - rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - device_req_o=0, device_we_o=0, device_be_o=0, device_addr_o=0, device_wdata_o=0.
- Command handshake in cycle N gives device_req_o=1 in cycle N+1.
- device_rvalid_i in cycle M gives rsp_valid_o=1 in cycle M+1.
- With a responder that answers one cycle after req (GPIO): handshake N, req N+1, rvalid N+2, rsp_valid N+3.
  - Next command is accepted at N+4 at earliest if rsp_ready_i=1 at N+3, giving a minimum of 4 cycles per transaction.
- Timeout path: rsp_valid_o asserts in cycle N+2+TimeoutCycles.
- cmd_ready_o and busy_o are decoded combinationally from state; all other outputs are registered.
- Reset mid-transaction: the transaction is abandoned, no response is produced, and no further device_req_o is issued.

## Test plan
- Write: cmd addr=0x0, we=1, be=4'b0001, wdata=0x0000_00A5; responder rvalid 1 cycle after req -> device_req_o high exactly 1 cycle with those fields; rsp_valid_o 1 cycle after rvalid with err=0, rdata=0.
- Read: cmd addr=0x4, we=0; responder returns 0x0000_5A5A -> rsp_rdata_o=0x0000_5A5A, err=0; total 4 cycles from handshake to IDLE with rsp_ready_i=1.
- Timeout: TimeoutCycles=16, responder silent -> rsp_valid_o at handshake+18 with err=1, rdata=0; a stray rvalid afterwards is ignored; the next command completes normally.
- Boundary: rvalid on the 16th WAIT cycle -> err=0 with the captured data; rvalid one cycle later -> err=1 and the late rvalid is ignored.
- Backpressure: rsp_ready_i low for 5 cycles -> rsp_valid_o/rdata/err stable, cmd_ready_o=0, busy_o=1, no device_req_o even with cmd_valid_i held high.
- Reset in WAIT: rst_i pulsed high for 1 cycle -> all outputs take reset values immediately, no response; a subsequent read to 0x4 completes correctly.

Source files
------------

// File: rtl/dev_bus_host.sv
// dev_bus_host: single-outstanding device bus initiator with a bounded wait for rvalid.
module dev_bus_host #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic                 cmd_we_i,
    input  logic [3:0]           cmd_be_i,
    input  logic [DataWidth-1:0] cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 device_req_o,
    output logic [AddrWidth-1:0] device_addr_o,
    output logic                 device_we_o,
    output logic [3:0]           device_be_o,
    output logic [DataWidth-1:0] device_wdata_o,
    input  logic                 device_rvalid_i,
    input  logic [DataWidth-1:0] device_rdata_i,
    output logic                 busy_o
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3;
    localparam int TW = $clog2(TimeoutCycles + 1);

    logic [1:0]    state;
    logic [TW-1:0] timer;

    assign cmd_ready_o = state == IDLE;
    assign busy_o      = state != IDLE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            timer          <= '0;
            rsp_valid_o    <= 1'b0;
            rsp_err_o      <= 1'b0;
            rsp_rdata_o    <= '0;
            device_req_o   <= 1'b0;
            device_addr_o  <= '0;
            device_we_o    <= 1'b0;
            device_be_o    <= '0;
            device_wdata_o <= '0;
        end else begin
            device_req_o <= 1'b0;
            case (state)
                IDLE: if (cmd_valid_i) begin
                    state          <= REQ;
                    device_req_o   <= 1'b1;
                    device_addr_o  <= cmd_addr_i;
                    device_we_o    <= cmd_we_i;
                    device_be_o    <= cmd_be_i;
                    device_wdata_o <= cmd_wdata_i;
                end
                REQ: begin
                    state <= WAIT;
                    timer <= '0;
                end
                // rvalid is tested first so it wins on the last permitted WAIT cycle
                WAIT: if (device_rvalid_i) begin
                    state       <= RESP;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= device_we_o ? '0 : device_rdata_i;
                end else if (timer == TW'(TimeoutCycles - 1)) begin
                    state       <= RESP;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b1;
                    rsp_rdata_o <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
                RESP: if (rsp_ready_i) begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dev_bus_host.sv
// tb_dev_bus_host: randomized self-checking bench for dev_bus_host against a latency/response model.
module tb_dev_bus_host;
    localparam int T = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i = '0;
    logic        cmd_we_i = 1'b0;
    logic [3:0]  cmd_be_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        device_req_o;
    logic [31:0] device_addr_o;
    logic        device_we_o;
    logic [3:0]  device_be_o;
    logic [31:0] device_wdata_o;
    logic        device_rvalid_i = 1'b0;
    logic [31:0] device_rdata_i = '0;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dev_bus_host #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
        .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .device_req_o(device_req_o), .device_addr_o(device_addr_o),
        .device_we_o(device_we_o), .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
        .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Runs one transaction with a responder answering d cycles after req (and an optional stray
    // rvalid at req+stray); records what was observed, leaving all judgement to the caller.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] wd, input logic [31:0] rd, input int d,
                          input int hold, input int stray, input bit keep_valid,
                          output int hs, output int req_cyc, output int nreq,
                          output logic [31:0] qa, output logic qw, output logic [3:0] qb,
                          output logic [31:0] qwd, output int rsp_cyc, output logic [31:0] rr,
                          output logic re, output int unstable, output int done_cyc);
        @(negedge clk_i);
        for (int k = 0; k < 50 && !cmd_ready_o; k++) @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_we_i = w; cmd_be_i = b; cmd_wdata_i = wd;
        hs = cyc; req_cyc = -1; nreq = 0; rsp_cyc = -1; unstable = 0; done_cyc = -1;
        qa = '0; qw = 1'b0; qb = '0; qwd = '0; rr = '0; re = 1'b0;
        for (int k = 0; k < 100 && done_cyc < 0; k++) begin
            @(negedge clk_i);
            if (!keep_valid) cmd_valid_i = 1'b0;
            if (device_req_o) begin
                nreq++;
                if (req_cyc < 0) begin
                    req_cyc = cyc; qa = device_addr_o; qw = device_we_o; qb = device_be_o; qwd = device_wdata_o;
                end
            end
            if (rsp_cyc >= 0 && rsp_ready_i) begin
                done_cyc = cyc;
                rsp_ready_i = 1'b0;
                if (rsp_valid_o || !cmd_ready_o) unstable++;
            end else if (rsp_valid_o) begin
                if (rsp_cyc < 0) begin
                    rsp_cyc = cyc; rr = rsp_rdata_o; re = rsp_err_o;
                end else if (rsp_rdata_o !== rr || rsp_err_o !== re) unstable++;
                if (cmd_ready_o || !busy_o) unstable++;
                rsp_ready_i = (cyc - rsp_cyc) >= hold;
            end
            device_rvalid_i = req_cyc >= 0 && (cyc == req_cyc + d || cyc == req_cyc + stray);
            device_rdata_i  = device_rvalid_i ? rd : $urandom;
        end
        cmd_valid_i = 1'b0;
        device_rvalid_i = 1'b0;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        #2;
        checks++;
        if ({cmd_ready_o, busy_o, rsp_valid_o, rsp_err_o, device_req_o, device_we_o} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctrl got %b want 100000", {cmd_ready_o, busy_o, rsp_valid_o, rsp_err_o, device_req_o, device_we_o});
        end
        repeat (2) @(negedge clk_i);
        checks++;
        if ({rsp_rdata_o, device_addr_o, device_wdata_o, device_be_o} !== 100'd0) begin
            errors++; $display("FAIL reset_data got %h want 0", {rsp_rdata_o, device_addr_o, device_wdata_o, device_be_o});
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({cmd_ready_o, busy_o, rsp_valid_o, device_req_o} !== 4'b1000) begin
            errors++; $display("FAIL reset_release got %b want 1000", {cmd_ready_o, busy_o, rsp_valid_o, device_req_o});
        end
    endtask

    task automatic test_write;
        int hs, rq, n, rc, u, dc; logic [31:0] qa, qwd, rr; logic qw, re; logic [3:0] qb;
        do_txn(32'h0, 1'b1, 4'b0001, 32'h0000_00A5, 32'hDEAD_BEEF, 1, 0, -1000, 1'b0,
               hs, rq, n, qa, qw, qb, qwd, rc, rr, re, u, dc);
        checks++;
        if (n !== 1 || rq !== hs + 1) begin
            errors++; $display("FAIL write_req count=%0d at=%0d want 1 at %0d", n, rq, hs + 1);
        end
        checks++;
        if ({qa, qw, qb, qwd} !== {32'h0, 1'b1, 4'b0001, 32'h0000_00A5}) begin
            errors++; $display("FAIL write_fields got %h %b %b %h", qa, qw, qb, qwd);
        end
        checks++;
        if (rc !== rq + 2 || re !== 1'b0 || rr !== 32'h0) begin
            errors++; $display("FAIL write_rsp at=%0d err=%b rdata=%h want at %0d err 0 rdata 0", rc, re, rr, rq + 2);
        end
    endtask

    task automatic test_read;
        int hs, rq, n, rc, u, dc; logic [31:0] qa, qwd, rr; logic qw, re; logic [3:0] qb;
        do_txn(32'h4, 1'b0, 4'b1111, 32'h1234_5678, 32'h0000_5A5A, 1, 0, -1000, 1'b0,
               hs, rq, n, qa, qw, qb, qwd, rc, rr, re, u, dc);
        checks++;
        if (rr !== 32'h0000_5A5A || re !== 1'b0 || rc !== hs + 3) begin
            errors++; $display("FAIL read_rsp rdata=%h err=%b at=%0d want 00005a5a 0 at %0d", rr, re, rc, hs + 3);
        end
        checks++;
        if (dc !== hs + 4 || qa !== 32'h4 || qw !== 1'b0) begin
            errors++; $display("FAIL read_latency idle_at=%0d addr=%h we=%b want idle at %0d", dc, qa, qw, hs + 4);
        end
    endtask

    task automatic test_timeout;
        int hs, rq, n, rc, u, dc; logic [31:0] qa, qwd, rr; logic qw, re; logic [3:0] qb;
        do_txn(32'h8, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FFFF, 1000, 2, T + 2, 1'b0,
               hs, rq, n, qa, qw, qb, qwd, rc, rr, re, u, dc);
        checks++;
        if (rc !== hs + 2 + T || re !== 1'b1 || rr !== 32'h0) begin
            errors++; $display("FAIL timeout_rsp at=%0d err=%b rdata=%h want at %0d err 1 rdata 0", rc, re, rr, hs + 2 + T);
        end
        checks++;
        if (u !== 0 || dc !== rc + 3) begin
            errors++; $display("FAIL timeout_stray unstable=%0d idle_at=%0d want 0 and %0d", u, dc, rc + 3);
        end
        device_rvalid_i = 1'b1; device_rdata_i = 32'h1111_1111;
        @(negedge clk_i);
        device_rvalid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({rsp_valid_o, busy_o, device_req_o} !== 3'b000) begin
            errors++; $display("FAIL idle_stray got %b want 000", {rsp_valid_o, busy_o, device_req_o});
        end
        do_txn(32'hC, 1'b0, 4'b0011, 32'h0, 32'h0BAD_F00D, 3, 0, -1000, 1'b0,
               hs, rq, n, qa, qw, qb, qwd, rc, rr, re, u, dc);
        checks++;
        if (rr !== 32'h0BAD_F00D || re !== 1'b0 || rc !== rq + 4) begin
            errors++; $display("FAIL after_timeout rdata=%h err=%b at=%0d want 0badf00d 0 at %0d", rr, re, rc, rq + 4);
        end
    endtask

    task automatic test_boundary;
        int hs, rq, n, rc, u, dc; logic [31:0] qa, qwd, rr; logic qw, re; logic [3:0] qb;
        do_txn(32'h10, 1'b0, 4'b1111, 32'h0, 32'hCAFE_0016, T, 0, -1000, 1'b0,
               hs, rq, n, qa, qw, qb, qwd, rc, rr, re, u, dc);
        checks++;
        if (rr !== 32'hCAFE_0016 || re !== 1'b0 || rc !== rq + T + 1) begin
            errors++; $display("FAIL boundary_last rdata=%h err=%b at=%0d want cafe0016 0 at %0d", rr, re, rc, rq + T + 1);
        end
        do_txn(32'h14, 1'b0, 4'b1111, 32'h0, 32'hCAFE_0017, T + 1, 0, -1000, 1'b0,
               hs, rq, n, qa, qw, qb, qwd, rc, rr, re, u, dc);
        checks++;
        if (rr !== 32'h0 || re !== 1'b1 || rc !== rq + T + 1) begin
            errors++; $display("FAIL boundary_late rdata=%h err=%b at=%0d want 0 1 at %0d", rr, re, rc, rq + T + 1);
        end
        checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || u !== 0) begin
            errors++; $display("FAIL boundary_ignored rsp_valid=%b busy=%b unstable=%0d want 0 0 0", rsp_valid_o, busy_o, u);
        end
    endtask

    task automatic test_backpressure;
        int hs, rq, n, rc, u, dc; logic [31:0] qa, qwd, rr; logic qw, re; logic [3:0] qb;
        do_txn(32'h18, 1'b0, 4'b1111, 32'h0, 32'h7777_0005, 2, 5, -1000, 1'b1,
               hs, rq, n, qa, qw, qb, qwd, rc, rr, re, u, dc);
        checks++;
        if (u !== 0 || n !== 1) begin
            errors++; $display("FAIL backpressure unstable=%0d reqs=%0d want 0 and 1", u, n);
        end
        checks++;
        if (dc !== rc + 6 || rr !== 32'h7777_0005 || re !== 1'b0) begin
            errors++; $display("FAIL backpressure_rsp idle_at=%0d rdata=%h err=%b want %0d 77770005 0", dc, rr, re, rc + 6);
        end
    endtask

    task automatic test_reset_wait;
        int hs, rq, n, rc, u, dc, bad; logic [31:0] qa, qwd, rr; logic qw, re; logic [3:0] qb;
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_addr_i = 32'hA0; cmd_we_i = 1'b1; cmd_be_i = 4'hF; cmd_wdata_i = 32'h5555_AAAA;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++;
        if ({cmd_ready_o, busy_o, rsp_valid_o, rsp_err_o, device_req_o, device_we_o} !== 6'b100000 ||
            {rsp_rdata_o, device_addr_o, device_wdata_o, device_be_o} !== 100'd0) begin
            errors++; $display("FAIL reset_wait ctrl=%b data=%h want 100000 and 0",
                {cmd_ready_o, busy_o, rsp_valid_o, rsp_err_o, device_req_o, device_we_o},
                {rsp_rdata_o, device_addr_o, device_wdata_o, device_be_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        bad = 0;
        for (int k = 0; k < T + 5; k++) begin
            @(negedge clk_i);
            if (rsp_valid_o || device_req_o || busy_o) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL reset_abandon activity_cycles=%0d want 0", bad);
        end
        do_txn(32'h4, 1'b0, 4'b1111, 32'h0, 32'h0000_5A5A, 1, 0, -1000, 1'b0,
               hs, rq, n, qa, qw, qb, qwd, rc, rr, re, u, dc);
        checks++;
        if (rr !== 32'h0000_5A5A || re !== 1'b0 || dc !== hs + 4 || qa !== 32'h4) begin
            errors++; $display("FAIL reset_then_read rdata=%h err=%b idle_at=%0d addr=%h want 00005a5a 0 %0d 4", rr, re, dc, qa, hs + 4);
        end
    endtask

    task automatic test_random;
        int hs, rq, n, rc, u, dc, d, hold, ex_rc; logic [31:0] qa, qwd, rr, a, wd, rd, ex_rd;
        logic qw, re, w, ex_err; logic [3:0] qb, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; wd = $urandom; rd = $urandom; w = 1'($urandom_range(0, 1));
            b = 4'($urandom_range(0, 15)); d = $urandom_range(1, T + 2); hold = $urandom_range(0, 3);
            do_txn(a, w, b, wd, rd, d, hold, -1000, 1'b0, hs, rq, n, qa, qw, qb, qwd, rc, rr, re, u, dc);
            ex_err = d > T;
            ex_rc  = rq + (ex_err ? T + 1 : d + 1);
            ex_rd  = (ex_err || w) ? 32'h0 : rd;
            checks++;
            if (n !== 1 || rq !== hs + 1 || {qa, qw, qb, qwd} !== {a, w, b, wd}) begin
                errors++; $display("FAIL rand_req[%0d] n=%0d at=%0d fields=%h want %h", i, n, rq, {qa, qw, qb, qwd}, {a, w, b, wd});
            end
            checks++;
            if (rc !== ex_rc || re !== ex_err || rr !== ex_rd || dc !== ex_rc + hold + 1 || u !== 0) begin
                errors++; $display("FAIL rand_rsp[%0d] at=%0d err=%b rdata=%h idle=%0d u=%0d want %0d %b %h %0d 0",
                    i, rc, re, rr, dc, u, ex_rc, ex_err, ex_rd, ex_rc + hold + 1);
            end
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_timeout;
        test_boundary;
        test_backpressure;
        test_reset_wait;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
